// File: rtl/bus_arbiter_if.sv
// Arbiter handshake bundle: master/slave request lines in, grant/command/status out.
// The master modport is the arbiter's view; the slave modport is the bus agents' view.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int NUM_SLAVES  = 3
);
    logic [NUM_MASTERS-1:0] m_req;
    logic [NUM_MASTERS-1:0] m_done;
    logic [NUM_SLAVES-1:0]  s_ready;
    logic [NUM_SLAVES-1:0]  s_done;
    logic [NUM_MASTERS-1:0] m_grant;
    logic [NUM_SLAVES-1:0]  s_cmd;
    logic                   bus_util;
    logic                   timeout_err;

    modport master (
        input  m_req, m_done, s_ready, s_done,
        output m_grant, s_cmd, bus_util, timeout_err
    );

    modport slave (
        output m_req, m_done, s_ready, s_done,
        input  m_grant, s_cmd, bus_util, timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Single-bus arbiter: slave responses beat master requests, grant 1 cycle after request, watchdog revokes stuck grants.
// Define ARB_ROUND_ROBIN_EN for round-robin master selection; otherwise fixed priority, lowest index wins.
module bus_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int NUM_SLAVES     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rstn,
    bus_arbiter_if.master  bus
);

    localparam logic [NUM_MASTERS-1:0] M_ONE   = NUM_MASTERS'(1);
    localparam logic [NUM_SLAVES-1:0]  S_ONE   = NUM_SLAVES'(1);
    localparam logic [7:0]             TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        M_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                 state;
    logic [7:0]             to_cnt;
    logic [NUM_SLAVES-1:0]  s_sel;   // slave being served; s_cmd itself is only a pulse
    logic [NUM_MASTERS-1:0] m_pick;
    logic [NUM_SLAVES-1:0]  s_pick;

`ifdef ARB_ROUND_ROBIN_EN
    localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    logic [MIW-1:0] rr_ptr;
    logic [MIW-1:0] rr_ptr_nxt;

    // rr_ptr is the first index searched; walking downwards lets the nearest hit win.
    always_comb begin
        int idx;
        idx        = 0;
        m_pick     = '0;
        rr_ptr_nxt = rr_ptr;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if ((bus.m_req & (M_ONE << idx)) != '0) begin
                m_pick     = M_ONE << idx;
                rr_ptr_nxt = (idx + 1 >= NUM_MASTERS) ? '0 : MIW'(idx + 1);
            end
        end
    end
`else
    always_comb begin
        m_pick = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if ((bus.m_req & (M_ONE << k)) != '0) m_pick = M_ONE << k;
        end
    end
`endif

    always_comb begin
        s_pick = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((bus.s_ready & (S_ONE << k)) != '0) s_pick = S_ONE << k;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            bus.m_grant     <= '0;
            bus.s_cmd       <= '0;
            bus.bus_util    <= 1'b1;
            bus.timeout_err <= 1'b0;
            to_cnt          <= '0;
            s_sel           <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr          <= '0;
`endif
        end else begin
            bus.s_cmd       <= '0;
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.s_ready != '0) begin
                        state        <= S_WAIT;
                        bus.s_cmd    <= s_pick;
                        s_sel        <= s_pick;
                        bus.bus_util <= 1'b0;
                        to_cnt       <= '0;
                    end else if (bus.m_req != '0) begin
                        state        <= M_GRANT;
                        bus.m_grant  <= m_pick;
                        bus.bus_util <= 1'b0;
                        to_cnt       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr       <= rr_ptr_nxt;
`endif
                    end
                end
                M_GRANT: begin
                    // A done in the final cycle is a clean release, so it is tested first.
                    if ((bus.m_done & bus.m_grant) != '0) begin
                        state        <= RELEASE;
                        bus.m_grant  <= '0;
                        bus.bus_util <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state           <= RELEASE;
                        bus.m_grant     <= '0;
                        bus.bus_util    <= 1'b1;
                        bus.timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if ((bus.s_done & s_sel) != '0) begin
                        state        <= RELEASE;
                        s_sel        <= '0;
                        bus.bus_util <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state           <= RELEASE;
                        s_sel           <= '0;
                        bus.bus_util    <= 1'b1;
                        bus.timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; expected values are hand-derived from the requirements.
module tb_bus_arbiter;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    bus_arbiter_if #(.NUM_MASTERS(3), .NUM_SLAVES(3)) bif ();

    bus_arbiter #(.NUM_MASTERS(3), .NUM_SLAVES(3), .TIMEOUT_CYCLES(255)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bif.m_req   = '0;
        bif.m_done  = '0;
        bif.s_ready = '0;
        bif.s_done  = '0;
        rstn        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bif.m_grant !== 3'b000 || bif.s_cmd !== 3'b000 || bif.bus_util !== 1'b1 || bif.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%b cmd=%b util=%b terr=%b, need 000 000 1 0",
                     bif.m_grant, bif.s_cmd, bif.bus_util, bif.timeout_err);
        end
    endtask

    task automatic test_basic_grant();
        bif.m_req = 3'b010;
        tick();
        checks++;
        if (bif.m_grant !== 3'b010 || bif.bus_util !== 1'b0) begin
            errors++;
            $display("FAIL grant_latency: grant=%b util=%b, need 010 0", bif.m_grant, bif.bus_util);
        end
        bif.m_req = 3'b000;
        tick();
        checks++;
        if (bif.m_grant !== 3'b010) begin
            errors++;
            $display("FAIL req_drop_holds: grant=%b, need 010", bif.m_grant);
        end
        bif.m_done = 3'b010;
        tick();
        bif.m_done = 3'b000;
        checks++;
        if (bif.m_grant !== 3'b000 || bif.bus_util !== 1'b1) begin
            errors++;
            $display("FAIL release: grant=%b util=%b, need 000 1", bif.m_grant, bif.bus_util);
        end
        tick();
        checks++;
        if (bif.m_grant !== 3'b000 || bif.bus_util !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_release: grant=%b util=%b, need 000 1", bif.m_grant, bif.bus_util);
        end
    endtask

    task automatic test_arbitration();
        logic [2:0] exp_g [3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{3'b001, 3'b010, 3'b001};
`else
        exp_g = '{3'b001, 3'b001, 3'b001};
`endif
        do_reset();
        bif.m_req = 3'b011;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bif.m_grant !== exp_g[i]) begin
                errors++;
                $display("FAIL arb_grant%0d: grant=%b, need %b", i, bif.m_grant, exp_g[i]);
            end
            bif.m_done = exp_g[i];
            tick();
            bif.m_done = 3'b000;
            checks++;
            if (bif.bus_util !== 1'b1 || bif.m_grant !== 3'b000) begin
                errors++;
                $display("FAIL arb_release%0d: util=%b grant=%b, need 1 000", i, bif.bus_util, bif.m_grant);
            end
            tick();
        end
        bif.m_req = 3'b000;
        tick();
    endtask

    task automatic test_slave_priority();
        bif.s_ready = 3'b100;
        bif.m_req   = 3'b001;
        tick();
        bif.s_ready = 3'b000;
        checks++;
        if (bif.s_cmd !== 3'b100 || bif.m_grant !== 3'b000 || bif.bus_util !== 1'b0) begin
            errors++;
            $display("FAIL slave_cmd: cmd=%b grant=%b util=%b, need 100 000 0", bif.s_cmd, bif.m_grant, bif.bus_util);
        end
        tick();
        checks++;
        if (bif.s_cmd !== 3'b000 || bif.m_grant !== 3'b000) begin
            errors++;
            $display("FAIL slave_cmd_pulse: cmd=%b grant=%b, need 000 000", bif.s_cmd, bif.m_grant);
        end
        bif.s_done = 3'b001;
        tick();
        bif.s_done = 3'b000;
        checks++;
        if (bif.bus_util !== 1'b0 || bif.m_grant !== 3'b000) begin
            errors++;
            $display("FAIL slave_other_done: util=%b grant=%b, need 0 000", bif.bus_util, bif.m_grant);
        end
        bif.s_done = 3'b100;
        tick();
        bif.s_done = 3'b000;
        checks++;
        if (bif.bus_util !== 1'b1 || bif.m_grant !== 3'b000) begin
            errors++;
            $display("FAIL slave_release: util=%b grant=%b, need 1 000", bif.bus_util, bif.m_grant);
        end
        tick();
        tick();
        checks++;
        if (bif.m_grant !== 3'b001 || bif.s_cmd !== 3'b000) begin
            errors++;
            $display("FAIL master_after_slave: grant=%b cmd=%b, need 001 000", bif.m_grant, bif.s_cmd);
        end
        bif.m_req  = 3'b000;
        bif.m_done = 3'b001;
        tick();
        bif.m_done = 3'b000;
        tick();
    endtask

    task automatic test_timeout();
        int held;
        do_reset();
        bif.m_req = 3'b001;
        tick();
        bif.m_req = 3'b000;
        held = 0;
        while (bif.m_grant === 3'b001 && held < 400) begin
            held++;
            tick();
        end
        checks++;
        if (held !== 255) begin
            errors++;
            $display("FAIL timeout_hold: held %0d cycles, need 255", held);
        end
        checks++;
        if (bif.timeout_err !== 1'b1 || bif.bus_util !== 1'b1 || bif.m_grant !== 3'b000) begin
            errors++;
            $display("FAIL timeout_pulse: terr=%b util=%b grant=%b, need 1 1 000",
                     bif.timeout_err, bif.bus_util, bif.m_grant);
        end
        tick();
        checks++;
        if (bif.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_one_cycle: terr=%b, need 0", bif.timeout_err);
        end
        // done arriving in the last allowed cycle
        bif.m_req = 3'b001;
        tick();
        bif.m_req = 3'b000;
        repeat (254) tick();
        checks++;
        if (bif.m_grant !== 3'b001) begin
            errors++;
            $display("FAIL grant_cycle255: grant=%b, need 001", bif.m_grant);
        end
        bif.m_done = 3'b001;
        tick();
        bif.m_done = 3'b000;
        checks++;
        if (bif.timeout_err !== 1'b0 || bif.m_grant !== 3'b000 || bif.bus_util !== 1'b1) begin
            errors++;
            $display("FAIL done_vs_timeout: terr=%b grant=%b util=%b, need 0 000 1",
                     bif.timeout_err, bif.m_grant, bif.bus_util);
        end
        tick();
    endtask

    task automatic test_ignore_and_async_reset();
        do_reset();
        bif.m_req = 3'b001;
        tick();
        bif.m_done = 3'b100;
        tick();
        bif.m_done = 3'b000;
        checks++;
        if (bif.m_grant !== 3'b001 || bif.bus_util !== 1'b0) begin
            errors++;
            $display("FAIL foreign_done: grant=%b util=%b, need 001 0", bif.m_grant, bif.bus_util);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (bif.m_grant !== 3'b000 || bif.bus_util !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: grant=%b util=%b, need 000 1", bif.m_grant, bif.bus_util);
        end
        bif.m_req = 3'b000;
        tick();
        rstn = 1'b1;
        tick();
        tick();
        checks++;
        if (bif.m_grant !== 3'b000 || bif.bus_util !== 1'b1) begin
            errors++;
            $display("FAIL no_memory: grant=%b util=%b, need 000 1", bif.m_grant, bif.bus_util);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_grant();
        test_arbitration();
        test_slave_priority();
        test_timeout();
        test_ignore_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
